// File: rtl/wb_regfile.sv
// wb_regfile -- Y86 pipeline write-back stage.
//
// Takes the W pipeline register contents and commits valE/valM into the
// program register file. Also provides the two combinational decode read
// ports. Processor status is tracked here: the first exceptional W_stat that
// reaches the stage is latched, and from then on all architectural state is
// frozen until reset. A retired-instruction counter counts committed AOK
// instructions.
//
// Ports:
//   clock    in   1      rising-edge clock
//   reset    in   1      synchronous, active-high reset
//   W_stall  in   1      W register held: no commit, no count, no state change
//   W_stat   in   4      status in W (0 SBUB, 1 AOK, 2 HLT, 3 ADR, 4 INS)
//   W_icode  in   4      icode in W (carried for completeness, not decoded)
//   W_dstE   in   4      destination for W_valE (4'hF = none)
//   W_dstM   in   4      destination for W_valM (4'hF = none)
//   W_valE   in   REG_W  ALU result
//   W_valM   in   REG_W  memory result
//   d_srcA   in   4      read port A register ID
//   d_srcB   in   4      read port B register ID
//   d_rvalA  out  REG_W  register[d_srcA], 0 for RNONE / out-of-range IDs
//   d_rvalB  out  REG_W  register[d_srcB], 0 for RNONE / out-of-range IDs
//   Stat     out  4      AOK while running, latched exception code once halted
//   halted   out  1      high once an exceptional status has been committed
//   retired  out  CNT_W  committed AOK instruction count (wraps)

module wb_regfile #(
  parameter int unsigned REG_W = 64,
  parameter int unsigned NREGS = 15,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             W_stall,
  input  logic [3:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic [REG_W-1:0] W_valE,
  input  logic [REG_W-1:0] W_valM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [REG_W-1:0] d_rvalA,
  output logic [REG_W-1:0] d_rvalB,
  output logic [3:0]       Stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] STAT_SBUB = 4'h0;
  localparam logic [3:0] STAT_AOK  = 4'h1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [REG_W-1:0] r_regs [NREGS];
  logic [3:0]       r_stat;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  logic             w_stat_ok;
  logic             w_commit;
  logic             w_halt;
  logic             w_count;
  logic [REG_W-1:0] w_rvalA;
  logic [REG_W-1:0] w_rvalB;
  logic             w_unused;

  // W_icode does not influence write-back behaviour here.
  assign w_unused = ^W_icode;

  // ---------------------------------------------------------------------------
  // Next-state / control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_stat_ok   = (W_stat == STAT_SBUB) || (W_stat == STAT_AOK);
    w_commit    = 1'b0;
    w_halt      = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!W_stall) begin
          if (w_stat_ok) begin
            w_commit = 1'b1;
            w_count  = (W_stat == STAT_AOK);
          end else begin
            w_halt      = 1'b1;
            w_state_nxt = S_HALTED;
          end
        end
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Status, halted flag, retired counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stat    <= STAT_AOK;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_halt) begin
        r_stat   <= W_stat;
        r_halted <= 1'b1;
      end
      if (w_count) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register file write. Matching only against implemented indices means
  // RNONE and any other out-of-range ID never write. The M port is checked
  // first so that it wins when both ports target the same register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (reset) begin
        r_regs[i] <= '0;
      end else if (w_commit && (W_dstM == i[3:0])) begin
        r_regs[i] <= W_valM;
      end else if (w_commit && (W_dstE == i[3:0])) begin
        r_regs[i] <= W_valE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read ports; unmatched IDs (RNONE, out-of-range) read 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rvalA = '0;
    w_rvalB = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (d_srcA == i[3:0]) w_rvalA = r_regs[i];
      if (d_srcB == i[3:0]) w_rvalB = r_regs[i];
    end
  end

  assign d_rvalA = w_rvalA;
  assign d_rvalB = w_rvalB;
  assign Stat    = r_stat;
  assign halted  = r_halted;
  assign retired = r_retired;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic        W_stall;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [63:0] d_rvalA;
  logic [63:0] d_rvalB;
  logic [3:0]  Stat;
  logic        halted;
  logic [31:0] retired;

  int tests;
  int fails;

  wb_regfile #(.REG_W(64), .NREGS(15), .CNT_W(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .W_stall (W_stall),
    .W_stat  (W_stat),
    .W_icode (W_icode),
    .W_dstE  (W_dstE),
    .W_dstM  (W_dstM),
    .W_valE  (W_valE),
    .W_valM  (W_valM),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .d_rvalA (d_rvalA),
    .d_rvalB (d_rvalB),
    .Stat    (Stat),
    .halted  (halted),
    .retired (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] stat, input logic [3:0] dste, input logic [63:0] vale,
                       input logic [3:0] dstm, input logic [63:0] valm);
    W_stat = stat;
    W_dstE = dste;
    W_valE = vale;
    W_dstM = dstm;
    W_valM = valm;
  endtask

  task automatic idle();
    W_stall = 1'b0;
    drive(4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    d_srcA = 4'h0;
    d_srcB = 4'hE;
    #1;
    tests++; if (Stat !== 4'h1) begin fails++; $display("FAIL reset_stat got=%0h exp=1", Stat); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    tests++; if (retired !== 32'd0) begin fails++; $display("FAIL reset_retired got=%0d exp=0", retired); end
    tests++; if (d_rvalA !== 64'h0) begin fails++; $display("FAIL reset_reg0 got=%0h exp=0", d_rvalA); end
    tests++; if (d_rvalB !== 64'h0) begin fails++; $display("FAIL reset_reg14 got=%0h exp=0", d_rvalB); end
  endtask

  task automatic test_basic_write();
    drive(4'h1, 4'h0, 64'h5, 4'hF, 64'h0);
    step();
    idle();
    d_srcA = 4'h0;
    #1;
    tests++; if (d_rvalA !== 64'h5) begin fails++; $display("FAIL basic_reg0 got=%0h exp=5", d_rvalA); end
    tests++; if (retired !== 32'd1) begin fails++; $display("FAIL basic_retired got=%0d exp=1", retired); end
    drive(4'h1, 4'hF, 64'h0, 4'hE, 64'hDEAD);
    step();
    idle();
    d_srcA = 4'hF;
    d_srcB = 4'hE;
    #1;
    tests++; if (d_rvalB !== 64'hDEAD) begin fails++; $display("FAIL basic_reg14 got=%0h exp=dead", d_rvalB); end
    tests++; if (d_rvalA !== 64'h0) begin fails++; $display("FAIL basic_rnone got=%0h exp=0", d_rvalA); end
    tests++; if (retired !== 32'd2) begin fails++; $display("FAIL basic_retired2 got=%0d exp=2", retired); end
  endtask

  task automatic test_same_dst();
    drive(4'h1, 4'h3, 64'hA, 4'h3, 64'hB);
    step();
    idle();
    d_srcA = 4'h3;
    #1;
    tests++; if (d_rvalA !== 64'hB) begin fails++; $display("FAIL samedst_reg3 got=%0h exp=b", d_rvalA); end
    tests++; if (retired !== 32'd3) begin fails++; $display("FAIL samedst_retired got=%0d exp=3", retired); end
    drive(4'h1, 4'hF, 64'h11, 4'hF, 64'h22);
    step();
    idle();
    #1;
    tests++; if (d_rvalA !== 64'hB) begin fails++; $display("FAIL nodst_reg3 got=%0h exp=b", d_rvalA); end
    tests++; if (retired !== 32'd4) begin fails++; $display("FAIL nodst_retired got=%0d exp=4", retired); end
  endtask

  task automatic test_bubble();
    drive(4'h0, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    step();
    step();
    tests++; if (retired !== 32'd4) begin fails++; $display("FAIL bubble_retired got=%0d exp=4", retired); end
    tests++; if (Stat !== 4'h1) begin fails++; $display("FAIL bubble_stat got=%0h exp=1", Stat); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL bubble_halted got=%0b exp=0", halted); end
    drive(4'h0, 4'h5, 64'h55, 4'hF, 64'h0);
    step();
    idle();
    d_srcA = 4'h5;
    #1;
    tests++; if (d_rvalA !== 64'h55) begin fails++; $display("FAIL bubble_reg5 got=%0h exp=55", d_rvalA); end
    tests++; if (retired !== 32'd4) begin fails++; $display("FAIL bubble_retired2 got=%0d exp=4", retired); end
  endtask

  task automatic test_stall();
    W_stall = 1'b1;
    drive(4'h1, 4'h1, 64'h9, 4'hF, 64'h0);
    d_srcA = 4'h1;
    step();
    tests++; if (d_rvalA !== 64'h0) begin fails++; $display("FAIL stall_reg1 got=%0h exp=0", d_rvalA); end
    tests++; if (retired !== 32'd4) begin fails++; $display("FAIL stall_retired got=%0d exp=4", retired); end
    drive(4'h2, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    tests++; if (Stat !== 4'h1) begin fails++; $display("FAIL stall_hlt_stat got=%0h exp=1", Stat); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL stall_hlt_halted got=%0b exp=0", halted); end
    W_stall = 1'b0;
    drive(4'h1, 4'h1, 64'h9, 4'hF, 64'h0);
    step();
    idle();
    #1;
    tests++; if (d_rvalA !== 64'h9) begin fails++; $display("FAIL unstall_reg1 got=%0h exp=9", d_rvalA); end
    tests++; if (retired !== 32'd5) begin fails++; $display("FAIL unstall_retired got=%0d exp=5", retired); end
  endtask

  task automatic test_back_to_back();
    d_srcA = 4'h6;
    d_srcB = 4'h7;
    drive(4'h1, 4'h6, 64'h60, 4'hF, 64'h0);
    step();
    tests++; if (d_rvalA !== 64'h60) begin fails++; $display("FAIL b2b_first got=%0h exp=60", d_rvalA); end
    drive(4'h1, 4'h7, 64'h70, 4'h6, 64'h61);
    step();
    tests++; if (d_rvalA !== 64'h61) begin fails++; $display("FAIL b2b_reg6 got=%0h exp=61", d_rvalA); end
    tests++; if (d_rvalB !== 64'h70) begin fails++; $display("FAIL b2b_reg7 got=%0h exp=70", d_rvalB); end
    drive(4'h1, 4'h6, 64'h62, 4'hF, 64'h0);
    step();
    idle();
    #1;
    tests++; if (d_rvalA !== 64'h62) begin fails++; $display("FAIL b2b_reg6b got=%0h exp=62", d_rvalA); end
    tests++; if (retired !== 32'd8) begin fails++; $display("FAIL b2b_retired got=%0d exp=8", retired); end
  endtask

  task automatic test_halt();
    d_srcA = 4'h2;
    drive(4'h3, 4'hF, 64'h0, 4'h2, 64'h7);
    step();
    idle();
    #1;
    tests++; if (d_rvalA !== 64'h0) begin fails++; $display("FAIL halt_reg2 got=%0h exp=0", d_rvalA); end
    tests++; if (Stat !== 4'h3) begin fails++; $display("FAIL halt_stat got=%0h exp=3", Stat); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_halted got=%0b exp=1", halted); end
    tests++; if (retired !== 32'd8) begin fails++; $display("FAIL halt_retired got=%0d exp=8", retired); end
    drive(4'h1, 4'h2, 64'h77, 4'hF, 64'h0);
    step();
    tests++; if (d_rvalA !== 64'h0) begin fails++; $display("FAIL halted_write got=%0h exp=0", d_rvalA); end
    tests++; if (retired !== 32'd8) begin fails++; $display("FAIL halted_retired got=%0d exp=8", retired); end
    drive(4'h2, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    tests++; if (Stat !== 4'h3) begin fails++; $display("FAIL halted_stat got=%0h exp=3", Stat); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halted_flag got=%0b exp=1", halted); end
  endtask

  task automatic test_reset_from_halt();
    logic [63:0] exp_v;
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    drive(4'h1, 4'h4, 64'h44, 4'hF, 64'h0);
    step();
    drive(4'h2, 4'hF, 64'h0, 4'hF, 64'h0);
    step();
    tests++; if (Stat !== 4'h2) begin fails++; $display("FAIL hlt_stat got=%0h exp=2", Stat); end
    tests++; if (halted !== 1'b1) begin fails++; $display("FAIL hlt_halted got=%0b exp=1", halted); end
    tests++; if (retired !== 32'd1) begin fails++; $display("FAIL hlt_retired got=%0d exp=1", retired); end
    reset = 1'b1;
    drive(4'h4, 4'h0, 64'hFF, 4'h1, 64'hEE);
    step();
    reset = 1'b0;
    idle();
    #1;
    exp_v = 64'h0;
    for (int i = 0; i < 15; i++) begin
      d_srcA = 4'(i);
      #1;
      tests++; if (d_rvalA !== exp_v) begin fails++; $display("FAIL rst_reg%0d got=%0h exp=0", i, d_rvalA); end
    end
    tests++; if (Stat !== 4'h1) begin fails++; $display("FAIL rst_stat got=%0h exp=1", Stat); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    tests++; if (retired !== 32'd0) begin fails++; $display("FAIL rst_retired got=%0d exp=0", retired); end
    d_srcA = 4'h8;
    drive(4'h1, 4'h8, 64'h88, 4'hF, 64'h0);
    step();
    idle();
    #1;
    tests++; if (d_rvalA !== 64'h88) begin fails++; $display("FAIL rst_run_reg8 got=%0h exp=88", d_rvalA); end
    tests++; if (retired !== 32'd1) begin fails++; $display("FAIL rst_run_retired got=%0d exp=1", retired); end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    reset   = 1'b1;
    W_stall = 1'b0;
    W_icode = 4'h0;
    d_srcA  = 4'hF;
    d_srcB  = 4'hF;
    idle();
    test_reset();
    test_basic_write();
    test_same_dst();
    test_bubble();
    test_stall();
    test_back_to_back();
    test_halt();
    test_reset_from_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
